// File: rtl/adel_loader_pkg.sv
// adel_loader_pkg: loader states, stream field widths and status-flag decode
package adel_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, WORD, CSUM, RUN, ERR} ldr_state_e;
  localparam int HDR_BITS = 8;
  localparam int CSUM_BITS = 8;
  localparam int WORD_BITS = 16;
  function automatic logic [2:0] flags(ldr_state_e s);
    return {s == HDR || s == WORD || s == CSUM, s == RUN, s == ERR};
  endfunction
endpackage

// File: rtl/adel_imem_loader_if.sv
// adel_imem_loader_if: serial load stream, fetch port and status of the imem loader
interface adel_imem_loader_if #(parameter int AW = 8, parameter int DW = 16);
  logic start;
  logic sdi;
  logic sdi_valid;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic core_nrst;
  logic busy;
  logic done;
  logic err;
  logic [AW:0] nwords;
  modport master (output start, sdi, sdi_valid, pc, input inst, core_nrst, busy, done, err, nwords);
  modport slave (input start, sdi, sdi_valid, pc, output inst, core_nrst, busy, done, err, nwords);
endinterface

// File: rtl/adel_imem_rf.sv
// adel_imem_rf: 2**AW x DW register array, one sync write port, one async read port
module adel_imem_rf #(parameter int AW = 8, parameter int DW = 16) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/adel_imem_loader.sv
// adel_imem_loader: serial boot loader into instruction memory, checksum gate on core reset
module adel_imem_loader
  import adel_loader_pkg::*;
#(parameter int AW = 8, parameter int DW = WORD_BITS) (
  input logic clk,
  input logic nrst,
  adel_imem_loader_if.slave bus
);
  localparam int CW = $clog2(DW);
  ldr_state_e state;
  logic [CW-1:0] bcnt;
  logic [DW-2:0] sh;
  logic [DW-1:0] sh_n, rdata;
  logic [CSUM_BITS-1:0] csum;
  logic [HDR_BITS-1:0] l;
  logic [AW-1:0] wptr;
  logic [AW:0] nwords;
  logic take, last, we, match, busy, done, err, core_nrst;
  assign sh_n = {sh, bus.sdi};
  assign l = sh_n[HDR_BITS-1:0];
  assign match = sh_n[CSUM_BITS-1:0] == csum;
  assign take = bus.sdi_valid && !bus.start && (state == HDR || state == WORD || state == CSUM);
  assign last = bcnt == CW'(state == WORD ? DW - 1 : state == HDR ? HDR_BITS - 1 : CSUM_BITS - 1);
  assign we = take && last && state == WORD;
  adel_imem_rf #(.AW(AW), .DW(DW)) u_rf (
    .clk(clk), .we(we), .waddr(wptr), .wdata(sh_n), .raddr(bus.pc), .rdata(rdata)
  );
  // stale words beyond the current session's count must never reach the core
  assign bus.inst = state == RUN && {1'b0, bus.pc} < nwords ? rdata : '0;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.core_nrst = core_nrst;
  assign bus.nwords = nwords;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      {busy, done, err} <= '0;
      core_nrst <= 1'b0;
      nwords <= '0;
      bcnt <= '0;
      sh <= '0;
      csum <= '0;
      wptr <= '0;
    end else begin
      core_nrst <= state == RUN;
      if (bus.start) begin
        state <= HDR;
        {busy, done, err} <= flags(HDR);
        bcnt <= '0;
        sh <= '0;
        csum <= '0;
        wptr <= '0;
      end else if (take) begin
        sh <= sh_n[DW-2:0];
        bcnt <= last ? '0 : bcnt + CW'(1);
        if (last) case (state)
          HDR: begin
            nwords <= l == '0 ? (AW+1)'(1 << AW) : (AW+1)'(l);
            csum <= l;
            wptr <= '0;
            state <= WORD;
            {busy, done, err} <= flags(WORD);
          end
          WORD: begin
            wptr <= wptr + AW'(1);
            csum <= csum ^ sh_n[DW-1 -: 8] ^ sh_n[7:0];
            if ({1'b0, wptr} + (AW+1)'(1) == nwords) begin
              state <= CSUM;
              {busy, done, err} <= flags(CSUM);
            end
          end
          CSUM: begin
            state <= match ? RUN : ERR;
            {busy, done, err} <= flags(match ? RUN : ERR);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adel_imem_loader.sv
// tb_adel_imem_loader: directed loads with a queue scoreboard for completions and output probes
module tb_adel_imem_loader;
  typedef enum logic [1:0] {K_INST, K_NW, K_CNRST, K_STAT} kind_e;
  typedef struct { kind_e kind; logic [15:0] exp; string name; } probe_t;
  typedef struct { logic done; logic err; logic [8:0] nw; } fin_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int tests = 0;
  int fails = 0;
  probe_t pq[$];
  fin_t fq[$];
  probe_t p;
  fin_t f;
  logic [15:0] act;
  logic probe_req = 1'b0;
  logic prev_fin = 1'b0;
  adel_imem_loader_if #(.AW(8), .DW(16)) bus ();
  adel_imem_loader #(.AW(8), .DW(16)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(string n, logic [15:0] a, logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // monitor: pops a completion record when done/err rises, a probe record on each probe strobe
  always @(negedge clk) begin
    if ((bus.done || bus.err) && !prev_fin) begin
      if (fq.size() == 0) check("fin_queue", 16'(fq.size()), 16'd1);
      else begin
        f = fq.pop_front();
        check("fin_done", {15'd0, bus.done}, {15'd0, f.done});
        check("fin_err", {15'd0, bus.err}, {15'd0, f.err});
        check("fin_nwords", {7'd0, bus.nwords}, {7'd0, f.nw});
      end
    end
    prev_fin = bus.done || bus.err;
    if (probe_req) begin
      if (pq.size() == 0) check("probe_queue", 16'(pq.size()), 16'd1);
      else begin
        p = pq.pop_front();
        case (p.kind)
          K_INST:  act = bus.inst;
          K_NW:    act = {7'd0, bus.nwords};
          K_CNRST: act = {15'd0, bus.core_nrst};
          default: act = {12'd0, bus.busy, bus.done, bus.err, bus.core_nrst};
        endcase
        check(p.name, act, p.exp);
      end
    end
  end

  task automatic probe(kind_e k, logic [7:0] pc, logic [15:0] e, string n);
    bus.pc = pc;
    pq.push_back('{k, e, n});
    probe_req = 1'b1;
    @(negedge clk);
    #1 probe_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bits(logic [15:0] v, int n, int duty);
    for (int i = n - 1; i >= 0; i--) begin
      while ($urandom_range(0, 99) >= duty) begin
        bus.sdi_valid = 1'b0;
        tick();
      end
      bus.sdi = v[i];
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
  endtask

  task automatic wait_fin();
    int n = 0;
    while (!(bus.done || bus.err) && n < 32) begin
      tick();
      n++;
    end
    check("fin_timeout", 16'(n < 32), 16'd1);
  endtask

  task automatic load(logic [7:0] l, logic [15:0] w[$], logic [7:0] cs, int duty, fin_t e);
    fq.push_back(e);
    start_pulse();
    send_bits({8'd0, l}, 8, duty);
    foreach (w[i]) send_bits(w[i], 16, duty);
    send_bits({8'd0, cs}, 8, duty);
    wait_fin();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w2[$];
    logic [15:0] w256[$];
    logic [15:0] w1[$];
    w2 = '{16'h1234, 16'hABCD};
    w1 = '{16'h0F0F};
    for (int i = 0; i < 256; i++) w256.push_back({i[7:0], ~i[7:0]});
    bus.start = 1'b0;
    bus.sdi = 1'b0;
    bus.sdi_valid = 1'b0;
    bus.pc = '0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    probe(K_STAT, 8'h00, 16'h0, "rst_status");
    probe(K_INST, 8'h00, 16'h0000, "rst_inst0");
    probe(K_NW, 8'h00, 16'd0, "rst_nwords");

    // L=2 checksum: 02^12^34^AB^CD = 42
    load(8'h02, w2, 8'h42, 100, '{1'b1, 1'b0, 9'd2});
    probe(K_CNRST, 8'h00, 16'd0, "run_cnrst_lag");
    tick();
    probe(K_CNRST, 8'h00, 16'd1, "run_cnrst");
    probe(K_INST, 8'h00, 16'h1234, "run_inst0");
    probe(K_INST, 8'h01, 16'hABCD, "run_inst1");
    probe(K_INST, 8'h02, 16'h0000, "run_inst2");
    probe(K_NW, 8'h00, 16'd2, "run_nwords");

    load(8'h02, w2, 8'h41, 100, '{1'b0, 1'b1, 9'd2});
    tick();
    probe(K_STAT, 8'h00, 16'b0010, "err_status");
    probe(K_INST, 8'h00, 16'h0000, "err_inst0");
    probe(K_INST, 8'h01, 16'h0000, "err_inst1");
    probe(K_INST, 8'h02, 16'h0000, "err_inst2");

    // {i,~i} words xor to FF each; 256 of them cancel, seed L=0
    load(8'h00, w256, 8'h00, 100, '{1'b1, 1'b0, 9'd256});
    probe(K_NW, 8'h00, 16'd256, "full_nwords");
    probe(K_INST, 8'hFF, 16'hFF00, "full_inst_ff");
    probe(K_INST, 8'h00, 16'h00FF, "full_inst_00");
    probe(K_INST, 8'h80, 16'h807F, "full_inst_80");

    load(8'h02, w2, 8'h42, 30, '{1'b1, 1'b0, 9'd2});
    tick();
    probe(K_STAT, 8'h00, 16'b0101, "gap_status");
    probe(K_INST, 8'h00, 16'h1234, "gap_inst0");
    probe(K_INST, 8'h01, 16'hABCD, "gap_inst1");
    probe(K_INST, 8'h02, 16'h0000, "gap_inst2");
    probe(K_NW, 8'h00, 16'd2, "gap_nwords");

    start_pulse();
    probe(K_STAT, 8'h00, 16'b1001, "restart_status");
    tick();
    probe(K_CNRST, 8'h00, 16'd0, "restart_cnrst_fall");
    send_bits(16'h0002, 8, 100);
    send_bits(16'h0015, 5, 100);
    probe(K_STAT, 8'h00, 16'b1000, "midword_status");
    nrst = 1'b0;
    probe(K_STAT, 8'h00, 16'b0000, "nrst_status");
    probe(K_NW, 8'h00, 16'd0, "nrst_nwords");
    probe(K_INST, 8'h00, 16'h0000, "nrst_inst0");
    nrst = 1'b1;
    tick();

    load(8'h01, w1, 8'h01, 100, '{1'b1, 1'b0, 9'd1});
    probe(K_INST, 8'h00, 16'h0F0F, "one_inst0");
    probe(K_INST, 8'h01, 16'h0000, "one_inst1");
    probe(K_NW, 8'h00, 16'd1, "one_nwords");

    repeat (2) tick();
    check("fin_leftover", 16'(fq.size()), 16'd0);
    check("probe_leftover", 16'(pq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
